// File: rtl/arb_pkg.sv
// arb_pkg: shared sizes, FSM state type and one-hot index helper for arb_rr16
package arb_pkg;
  localparam int NUM_REQ = 16;
  localparam int PTR_W = 4;
  typedef enum logic {IDLE, GRANT} state_t;
  function automatic logic [PTR_W-1:0] onehot_idx(input logic [NUM_REQ-1:0] v);
    onehot_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (v[i]) onehot_idx = onehot_idx | PTR_W'(i);
  endfunction
endpackage

// File: rtl/rr_pick16.sv
// rr_pick16: one-hot pick of the first set req bit at or after ptr, searching cyclically
module rr_pick16 import arb_pkg::*; (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic               any
);
  logic [PTR_W:0] back_sh;
  logic [NUM_REQ-1:0] rot, low;
  always_comb begin
    back_sh = (PTR_W+1)'(NUM_REQ) - {1'b0, ptr};
    rot = (req >> ptr) | (req << back_sh);
    low = rot & (~rot + NUM_REQ'(1));
    pick = (low << ptr) | (low >> back_sh);
    any = |req;
  end
endmodule

// File: rtl/arb_rr16.sv
// arb_rr16: 16-way round-robin arbiter with registered one-hot grant; ARB_LOCK_EN adds a lock input that keeps the owner across ack
module arb_rr16 import arb_pkg::*; #(
  parameter int unsigned PTR_RESET = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               ack,
`ifdef ARB_LOCK_EN
  input  logic               lock,
`endif
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid
);
  state_t state, state_d;
  logic [PTR_W-1:0] ptr, ptr_d, idx, pick_ptr;
  logic [NUM_REQ-1:0] grant_d, pick;
  logic any, serve, keep;
`ifdef ARB_LOCK_EN
  assign keep = serve && lock && |(req & grant);
`else
  assign keep = 1'b0;
`endif
  assign idx = onehot_idx(grant);
  assign serve = state == GRANT && ack;
  // on ack the search starts just past the served index, so it becomes lowest priority
  assign pick_ptr = state == GRANT ? idx + PTR_W'(1) : ptr;
  rr_pick16 u_pick (.req(req), .ptr(pick_ptr), .pick(pick), .any(any));
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      ptr <= PTR_W'(PTR_RESET);
      grant <= '0;
    end else begin
      state <= state_d;
      ptr <= ptr_d;
      grant <= grant_d;
    end
  end
  always_comb state_d = (state == GRANT && !ack) || keep || any ? GRANT : IDLE;
  always_comb begin
    grant_d = (state == GRANT && !ack) || keep ? grant : pick;
    ptr_d = serve && !keep ? idx + PTR_W'(1) : ptr;
  end
  assign grant_valid = state == GRANT;
endmodule
